sw_debounce: RTL and testbench
==============================

Name: sw_debounce

Overview:
- Input conditioning stage directly upstream of the switch-programmed clock-divider top (`main`).
- Takes the raw 8-bit board switch bus, synchronizes it into the CLK domain and debounces it as a whole word.
- Presents a glitch-free switch value plus a one-cycle change strobe, so the divider never sees a metastable or bouncing value.

Parameters:
- WIDTH, 8: switch bus width.
- STABLE_CYCLES, 100000: consecutive CLK cycles the synchronized value must hold before commit; legal range ≥2.
- CNT_W, $clog2(STABLE_CYCLES): width of the settle counter; derived, never overridden.

Ports:
- CLK  in  1  system clock, rising-edge.
- RST_N  in  1  synchronous active-low reset, sampled on rising CLK.
- SW_RAW  in  WIDTH  raw asynchronous switch inputs.
- SW  out  WIDTH  debounced switch value (feeds `main.SW`).
- SW_VALID  out  1  high once the first stable value has been committed after reset.
- SW_CHG  out  1  one-cycle pulse on every commit.

Behaviour:
- One clock domain (CLK). Reset is synchronous and active-low (RST_N).
- Reset (RST_N=0 at a rising edge): sync1, sync2, cand, cnt, SW all 0; SW_VALID=0; SW_CHG=0; state=IDLE.
- Reset asserted mid-SETTLE aborts the settle; no commit occurs.
- Synchronizer:
  - Two flops: sync1<=SW_RAW, sync2<=sync1.
  - s = sync2 is the only value the FSM examines.
- State IDLE:
  - Condition: s!=SW or SW_VALID=0.
  - Action: go to SETTLE, cand<=s, cnt<=0.
  - Otherwise stay in IDLE.
- State SETTLE:
  - If s!=cand and (SW_VALID=1 and s==SW): go to IDLE (bounce back to the committed value, no commit).
  - Else if s!=cand: cand<=s, cnt<=0; stay in SETTLE (restart).
  - Else if cnt==STABLE_CYCLES-1: commit and go to IDLE.
    - SW<=cand; SW_VALID<=1; SW_CHG<=1 for exactly one cycle.
  - Else cnt<=cnt+1.
- Counter:
  - Unsigned CNT_W bits.
  - Never exceeds STABLE_CYCLES-1, so no wrap.
- SW_CHG:
  - Registered.
  - Deasserts the cycle after commit.
  - First commit after reset pulses SW_CHG even if the value is 0.
- Latency:
  - Counting the edge that first captures a new stable SW_RAW into sync1 as edge 1, SW and SW_CHG update at edge STABLE_CYCLES+3.
- SW holds its value at all times except at a commit edge.
- Multiple bits changing at different times are treated as one word. Any bit change restarts the count.
- A SW_RAW pulse shorter than STABLE_CYCLES cycles (post-synchronizer) never reaches SW.
- A change whose settled value equals the current SW produces no commit and no SW_CHG.
- Exception to the above: the first commit after reset.

Optional Feature:
- Macro: SW_BOUNCE_CNT_EN.
- When defined, adds output port BOUNCE_CNT (out, 8 bits).
  - Increments each time SETTLE restarts or aborts because s!=cand.
  - Saturates at 255.
  - Cleared to 0 by reset only.
  - Not cleared by commits.
- When undefined, the port and its logic are absent and the block behaves identically otherwise.

Test Plan (STABLE_CYCLES=4, CLK period 10 ns):
- Reset hold:
  - Stimulus: RST_N=0 for 3 edges, SW_RAW=8'hA5.
  - Required: SW=0, SW_VALID=0, SW_CHG=0 throughout.
  - After RST_N=1: SW=8'hA5, SW_VALID=1, and a single SW_CHG pulse at edge 7 after the first sampling edge.
- Clean change:
  - Stimulus: from SW=8'h01, set SW_RAW=8'h02 and hold.
  - Required: SW becomes 8'h02 exactly 7 edges after first capture; SW_CHG high for 1 cycle only.
- Bounce rejection:
  - Stimulus: from SW=8'h02, toggle SW_RAW 8'h02/8'h03 every 2 cycles for 20 cycles, then hold 8'h02.
  - Required: SW stays 8'h02, SW_CHG never asserts.
  - With SW_BOUNCE_CNT_EN defined: BOUNCE_CNT > 0.
- Bounce then settle:
  - Stimulus: toggle 8'h02/8'h80 for 10 cycles, then hold 8'h80.
  - Required: SW=8'h80 exactly 7 edges after the last toggle is captured; one SW_CHG pulse.
- Reset mid-settle:
  - Stimulus: SW_RAW 8'h10→8'h20; assert RST_N=0 two edges into SETTLE.
  - Required: SW=0, SW_VALID=0 the edge after reset.
  - After release: SW=8'h20 following the full 7-edge latency.
- Full sweep:
  - Stimulus: step SW_RAW through 1..255, holding each value 8 cycles.
  - Required: SW tracks each value with no skipped or duplicated SW_CHG pulses (255 total including the first commit).

Source files
------------

// File: rtl/sw_debounce.sv
// Two-flop synchronizer plus whole-word debouncer for the switch bus feeding the clock divider.
// Optional SW_BOUNCE_CNT_EN adds an 8-bit saturating BOUNCE_CNT output.
module sw_debounce #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 100000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] SW_RAW,
  output logic [WIDTH-1:0] SW,
  output logic             SW_VALID,
  output logic             SW_CHG
`ifdef SW_BOUNCE_CNT_EN
  ,
  output logic [7:0]       BOUNCE_CNT
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    IDLE,
    SETTLE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sync1_q, sync2_q;
  logic [WIDTH-1:0]   cand_q, cand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   swReg_q, swReg_d;
  logic               swValid_q, swValid_d;
  logic               swChg_q, swChg_d;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      state_q   <= IDLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      swReg_q   <= '0;
      swValid_q <= 1'b0;
      swChg_q   <= 1'b0;
    end else begin
      sync1_q   <= SW_RAW;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      swReg_q   <= swReg_d;
      swValid_q <= swValid_d;
      swChg_q   <= swChg_d;
    end
  end

  // While settling, cand always equals sync2 unless the word just moved; any move restarts the count.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    swReg_d   = swReg_q;
    swValid_d = swValid_q;
    swChg_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if ((sync2_q != swReg_q) || !swValid_q) begin
          state_d = SETTLE;
          cand_d  = sync2_q;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (sync2_q != cand_q) begin
          if (swValid_q && (sync2_q == swReg_q)) begin
            state_d = IDLE;
          end else begin
            cand_d = sync2_q;
            cnt_d  = '0;
          end
        end else if (cnt_q == CNT_MAX) begin
          swReg_d   = cand_q;
          swValid_d = 1'b1;
          swChg_d   = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign SW       = swReg_q;
  assign SW_VALID = swValid_q;
  assign SW_CHG   = swChg_q;

`ifdef SW_BOUNCE_CNT_EN
  logic       bounceEvent;
  logic [7:0] bounceCnt_q;

  assign bounceEvent = (state_q == SETTLE) && (sync2_q != cand_q);

  // Counts both restarts and bounce-back aborts; only reset clears it.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      bounceCnt_q <= '0;
    end else if (bounceEvent && (bounceCnt_q != 8'hFF)) begin
      bounceCnt_q <= bounceCnt_q + 8'd1;
    end
  end

  assign BOUNCE_CNT = bounceCnt_q;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce: vector table, directed corner sequences and a
// window-based reference model (commit when the synchronized word held for STABLE+1 examined edges).
module tb_sw_debounce;

  localparam int STABLE = 4;

  logic       CLK;
  logic       RST_N;
  logic [7:0] SW_RAW;
  logic [7:0] SW;
  logic       SW_VALID;
  logic       SW_CHG;
`ifdef SW_BOUNCE_CNT_EN
  logic [7:0] BOUNCE_CNT;
`endif

  sw_debounce #(
    .WIDTH(8),
    .STABLE_CYCLES(STABLE)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .SW_RAW(SW_RAW),
    .SW(SW),
    .SW_VALID(SW_VALID),
    .SW_CHG(SW_CHG)
`ifdef SW_BOUNCE_CNT_EN
    ,
    .BOUNCE_CNT(BOUNCE_CNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int chgCount = 0;

  typedef struct {
    logic       rstN;
    logic [7:0] raw;
    logic [7:0] sw;
    logic       valid;
    logic       chg;
  } vec_t;
  vec_t vecs[$];

  // Reference model state: the synchronizer is a two-deep delay line of raw samples,
  // hist holds the most recent examined words since reset.
  logic [7:0] rawQ[$] = '{8'h00, 8'h00};
  logic [7:0] hist[$];
  logic [7:0] mSw = 8'h00;
  logic       mValid = 1'b0;
  logic       mChg = 1'b0;

  task automatic modelEdge(input logic rst, input logic [7:0] raw);
    logic [7:0] s;
    logic       allSame;
    if (!rst) begin
      rawQ   = '{8'h00, 8'h00};
      hist.delete();
      mSw    = 8'h00;
      mValid = 1'b0;
      mChg   = 1'b0;
    end else begin
      s = rawQ.pop_front();
      rawQ.push_back(raw);
      hist.push_back(s);
      if (hist.size() > STABLE + 1) void'(hist.pop_front());
      mChg = 1'b0;
      if (hist.size() == STABLE + 1) begin
        allSame = 1'b1;
        foreach (hist[i]) if (hist[i] != hist[0]) allSame = 1'b0;
        if (allSame && ((hist[0] != mSw) || !mValid)) begin
          mSw    = hist[0];
          mValid = 1'b1;
          mChg   = 1'b1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [7:0] raw);
    RST_N  = rst;
    SW_RAW = raw;
    modelEdge(rst, raw);
    @(posedge CLK);
    @(negedge CLK);
    if (SW_CHG) chgCount++;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] expSw,
                             input logic expValid, input logic expChg);
    checks++;
    if ((SW !== expSw) || (SW_VALID !== expValid) || (SW_CHG !== expChg)) begin
      errors++;
      $display("[TB] FAIL %s: got SW=%h SW_VALID=%b SW_CHG=%b, expected SW=%h SW_VALID=%b SW_CHG=%b (t=%0t)",
               name, SW, SW_VALID, SW_CHG, expSw, expValid, expChg, $time);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic stepModel(input logic rst, input logic [7:0] raw);
    applyStimulus(rst, raw);
    checkOutput("model", mSw, mValid, mChg);
  endtask

  function automatic void addRows(input logic rst, input logic [7:0] raw, input int n,
                                  input logic [7:0] sw, input logic valid, input logic chg);
    for (int i = 0; i < n; i++) vecs.push_back('{rst, raw, sw, valid, chg});
  endfunction

  initial begin
    int n;
    logic seen;
    logic [7:0] v;

    RST_N  = 1'b0;
    SW_RAW = 8'hA5;

    // Reset hold, first commit at edge 7, then clean changes A5->01->02.
    addRows(1'b0, 8'hA5, 3, 8'h00, 1'b0, 1'b0);
    addRows(1'b1, 8'hA5, 6, 8'h00, 1'b0, 1'b0);
    addRows(1'b1, 8'hA5, 1, 8'hA5, 1'b1, 1'b1);
    addRows(1'b1, 8'hA5, 1, 8'hA5, 1'b1, 1'b0);
    addRows(1'b1, 8'h01, 6, 8'hA5, 1'b1, 1'b0);
    addRows(1'b1, 8'h01, 1, 8'h01, 1'b1, 1'b1);
    addRows(1'b1, 8'h01, 2, 8'h01, 1'b1, 1'b0);
    addRows(1'b1, 8'h02, 6, 8'h01, 1'b1, 1'b0);
    addRows(1'b1, 8'h02, 1, 8'h02, 1'b1, 1'b1);
    addRows(1'b1, 8'h02, 2, 8'h02, 1'b1, 1'b0);

    $display("[TB] table vectors");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rstN, vecs[i].raw);
      checkOutput($sformatf("vec%0d", i), vecs[i].sw, vecs[i].valid, vecs[i].chg);
    end

    $display("[TB] bounce rejection");
    chgCount = 0;
    for (int i = 0; i < 20; i++) stepModel(1'b1, ((i / 2) % 2) ? 8'h03 : 8'h02);
    for (int i = 0; i < 10; i++) stepModel(1'b1, 8'h02);
    checkValue("bounce_chg_count", chgCount, 0);
    checkValue("bounce_sw", int'(SW), 8'h02);
`ifdef SW_BOUNCE_CNT_EN
    checkValue("bounce_cnt_nonzero", int'(BOUNCE_CNT != 8'h00), 1);
`endif

    $display("[TB] bounce then settle");
    chgCount = 0;
    for (int i = 0; i < 10; i++) stepModel(1'b1, (i % 2) ? 8'h80 : 8'h02);
    n = 1;
    seen = 1'b0;
    while (!seen && (n < 20)) begin
      stepModel(1'b1, 8'h80);
      n++;
      if (SW_CHG) seen = 1'b1;
    end
    checkValue("settle_latency", n, 7);
    for (int i = 0; i < 5; i++) stepModel(1'b1, 8'h80);
    checkValue("settle_chg_count", chgCount, 1);
    checkValue("settle_sw", int'(SW), 8'h80);

    $display("[TB] reset mid-settle");
    for (int i = 0; i < 10; i++) stepModel(1'b1, 8'h10);
    for (int i = 0; i < 4; i++) stepModel(1'b1, 8'h20);
    stepModel(1'b0, 8'h20);
    checkOutput("reset_mid", 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      stepModel(1'b1, 8'h20);
      checkOutput("reset_wait", 8'h00, 1'b0, 1'b0);
    end
    stepModel(1'b1, 8'h20);
    checkOutput("reset_release", 8'h20, 1'b1, 1'b1);

    $display("[TB] full sweep");
    stepModel(1'b0, 8'h01);
    chgCount = 0;
    for (int k = 1; k < 256; k++) begin
      v = 8'(k);
      for (int j = 0; j < 8; j++) stepModel(1'b1, v);
    end
    checkValue("sweep_chg_count", chgCount, 255);
    checkValue("sweep_final_sw", int'(SW), 8'hFF);

    $display("[TB] random runs");
    for (int r = 0; r < 600; r++) begin
      logic rst;
      int len;
      rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      v   = 8'($urandom_range(0, 3)) << ($urandom_range(0, 1) * 4);
      len = rst ? $urandom_range(1, 8) : 1;
      for (int j = 0; j < len; j++) stepModel(rst, v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
